// File: rtl/stack_op_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// stack_op_seq: runs one RPN operation on the operand stack via push/pop pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module stack_op_seq #(
  parameter int WIDTH  = 32,
  parameter int SIZE_W = 10,
  parameter int DEPTH  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  stack_top,
  input  logic [SIZE_W-1:0] stack_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [WIDTH-1:0]  stack_in
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_POP1, S_SET1, S_POP2, S_SET2, S_EXEC,
    S_PUSH1, S_SETP1, S_PUSH2, S_SETP2, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               push_q, push_d, pop_q, pop_d;
  logic [WIDTH-1:0]   stack_in_q, stack_in_d;

  logic               size_ok, div_zero, reject, is_div;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [WIDTH-1:0]   rem_step, quo_step, mul_res, alu_res;

  // One restoring-division step: shift in the next dividend bit, try subtracting A
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, a_q};
    rem_step  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
  end

  assign mul_res = b_q * a_q;
  assign is_div  = (op_q == OP_DIV) || (op_q == OP_MOD);

  always_comb begin
    alu_res = rem_step;
    case (op_q)
      OP_ADD:  alu_res = b_q + a_q;
      OP_SUB:  alu_res = b_q - a_q;
      OP_MUL:  alu_res = mul_res;
      OP_DIV:  alu_res = quo_step;
      default: alu_res = rem_step;
    endcase
  end

  always_comb begin
    case (op)
      OP_POP:  size_ok = (stack_size >= SIZE_W'(1));
      OP_DUP:  size_ok = (stack_size >= SIZE_W'(1)) && (stack_size < SIZE_W'(DEPTH));
      default: size_ok = (stack_size >= SIZE_W'(2));
    endcase
    div_zero = ((op == OP_DIV) || (op == OP_MOD)) && (stack_top == '0);
    reject   = !size_ok || div_zero;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    stack_in_d = stack_in_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reject) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            a_d  = stack_top;
            op_d = op;
            if (op == OP_DUP) begin
              state_d    = S_PUSH1;
              stack_in_d = stack_top;
            end else begin
              state_d = S_POP1;
            end
          end
        end
      end
      S_POP1: state_d = S_SET1;
      S_SET1: begin
        b_d     = stack_top;
        state_d = (op_q == OP_POP) ? S_DONE : S_POP2;
      end
      S_POP2: state_d = S_SET2;
      S_SET2: begin
        rem_d = '0;
        quo_d = b_q;
        cnt_d = '0;
        if (op_q == OP_SWAP) begin
          state_d    = S_PUSH1;
          stack_in_d = a_q;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Divider holds EXEC for WIDTH cycles; the last step feeds the push directly
        if (is_div && (cnt_q != CNT_W'(WIDTH - 1))) begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d    = S_PUSH1;
          stack_in_d = alu_res;
        end
      end
      S_PUSH1: state_d = S_SETP1;
      S_SETP1: begin
        if (op_q == OP_SWAP) begin
          state_d    = S_PUSH2;
          stack_in_d = b_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PUSH2: state_d = S_SETP2;
      S_SETP2: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register cleanly
    busy_d = (state_d != S_IDLE);
    done_d = done_d | (state_d == S_DONE);
    push_d = (state_d == S_PUSH1) || (state_d == S_PUSH2);
    pop_d  = (state_d == S_POP1) || (state_d == S_POP2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      stack_in_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      stack_in_q <= stack_in_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign stack_push = push_q;
  assign stack_pop  = pop_q;
  assign stack_in   = stack_in_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_op_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_stack_op_seq: scoreboard bench with a behavioural stack attached
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stack_op_seq;

  localparam int WIDTH = 32;
  localparam int SIZE_W = 10;
  localparam int DEPTH = 1023;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4, OP_POP = 3'd5, OP_SWAP = 3'd6, OP_DUP = 3'd7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        op = 3'd0;
  logic [WIDTH-1:0]  stack_top;
  logic [SIZE_W-1:0] stack_size;
  logic              busy, done, err, stack_push, stack_pop;
  logic [WIDTH-1:0]  stack_in;

  stack_op_seq #(.WIDTH(WIDTH), .SIZE_W(SIZE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .stack_top(stack_top), .stack_size(stack_size),
    .busy(busy), .done(done), .err(err),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_in(stack_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural operand stack
  logic [WIDTH-1:0]  stk [0:1023];
  logic [SIZE_W-1:0] stk_size;
  logic              ld_en = 1'b0;
  logic [SIZE_W-1:0] ld_size = '0;
  logic [WIDTH-1:0]  ld_a = '0, ld_b = '0;

  always @(posedge clk) begin
    if (ld_en) begin
      stk_size <= ld_size;
      if (ld_size >= 1) stk[ld_size - 1] <= ld_a;
      if (ld_size >= 2) stk[ld_size - 2] <= ld_b;
    end else if (stack_pop && stk_size != 0) begin
      stk_size <= stk_size - 1;
    end else if (stack_push) begin
      stk[stk_size] <= stack_in;
      stk_size <= stk_size + 1;
    end
  end

  assign stack_top  = (stk_size == 0) ? '0 : stk[stk_size - 1];
  assign stack_size = stk_size;

  typedef struct { int cyc; logic [WIDTH-1:0] val; } push_exp_t;
  typedef struct { int cyc; logic err; } done_exp_t;
  push_exp_t push_q[$];
  int        pop_q[$];
  done_exp_t done_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    int        pe;
    push_exp_t ue;
    done_exp_t de;
    if (stack_push && stack_pop) check("pulse_overlap", 64'({stack_push, stack_pop}), 64'(0));
    if (prev_pulse && (stack_push || stack_pop))
      check("pulse_gap", 64'({stack_push, stack_pop}), 64'(0));
    prev_pulse = stack_push || stack_pop;
    if (stack_pop) begin
      if (pop_q.size() == 0) check("pop_unexpected", 64'(stack_pop), 64'(0));
      else begin
        pe = pop_q.pop_front();
        check("pop_cycle", 64'(cyc), 64'(pe));
      end
    end
    if (stack_push) begin
      if (push_q.size() == 0) check("push_unexpected", 64'(stack_push), 64'(0));
      else begin
        ue = push_q.pop_front();
        check("push_cycle", 64'(cyc), 64'(ue.cyc));
        check("push_value", 64'(stack_in), 64'(ue.val));
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'(0));
      else begin
        de = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(de.cyc));
        check("err", 64'(err), 64'(de.err));
      end
    end
    if (err && !done) check("err_without_done", 64'(done), 64'(1));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic exp_push(input int c, input logic [WIDTH-1:0] v);
    push_exp_t e;
    e.cyc = c;
    e.val = v;
    push_q.push_back(e);
  endtask

  task automatic exp_done(input int c, input logic e_err);
    done_exp_t e;
    e.cyc = c;
    e.err = e_err;
    done_q.push_back(e);
  endtask

  task automatic run_op(input logic [2:0] o, input bit do_load, input int sz,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] a, input bit poke);
    int               t, sz0, exp_sz, d0;
    logic [WIDTH-1:0] av, bv, res, exp_top;
    bit               rej;
    if (do_load) begin
      ld_en = 1'b1;
      ld_size = SIZE_W'(sz);
      ld_a = a;
      ld_b = b;
      tick();
      ld_en = 1'b0;
    end
    sz0 = int'(stk_size);
    av  = stack_top;
    bv  = (sz0 >= 2) ? stk[sz0 - 2] : '0;
    case (o)
      OP_POP:  rej = (sz0 < 1);
      OP_DUP:  rej = (sz0 < 1) || (sz0 >= DEPTH);
      default: rej = (sz0 < 2) || (((o == OP_DIV) || (o == OP_MOD)) && av == 0);
    endcase
    res = '0;
    if (!rej) begin
      case (o)
        OP_ADD:  res = bv + av;
        OP_SUB:  res = bv - av;
        OP_MUL:  res = bv * av;
        OP_DIV:  res = bv / av;
        OP_MOD:  res = bv % av;
        default: res = '0;
      endcase
    end
    t = cyc;
    exp_sz = sz0;
    exp_top = av;
    if (rej) begin
      exp_done(t + 1, 1'b1);
    end else begin
      case (o)
        OP_POP: begin
          pop_q.push_back(t + 1);
          exp_done(t + 3, 1'b0);
          exp_sz = sz0 - 1;
          exp_top = bv;
        end
        OP_SWAP: begin
          pop_q.push_back(t + 1);
          pop_q.push_back(t + 3);
          exp_push(t + 5, av);
          exp_push(t + 7, bv);
          exp_done(t + 9, 1'b0);
          exp_top = bv;
        end
        OP_DUP: begin
          exp_push(t + 1, av);
          exp_done(t + 3, 1'b0);
          exp_sz = sz0 + 1;
        end
        default: begin
          pop_q.push_back(t + 1);
          pop_q.push_back(t + 3);
          if (o == OP_DIV || o == OP_MOD) begin
            exp_push(t + 5 + WIDTH, res);
            exp_done(t + 7 + WIDTH, 1'b0);
          end else begin
            exp_push(t + 6, res);
            exp_done(t + 8, 1'b0);
          end
          exp_sz = sz0 - 1;
          exp_top = res;
        end
      endcase
    end
    d0 = done_cnt;
    start = 1'b1;
    op = o;
    tick();
    start = 1'b0;
    op = ~o;
    check("busy_after_start", 64'(busy), 64'(!rej));
    if (poke && !rej) begin
      tick();
      start = 1'b1;
      op = OP_POP;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check("done_timeout", 64'(done_cnt), 64'(d0 + 1));
    tick();
    check("busy_after_done", 64'(busy), 64'(0));
    tick();
    tick();
    check("final_size", 64'(stk_size), 64'(exp_sz));
    check("final_top", 64'(stack_top), 64'(exp_top));
    if (o == OP_SWAP && !rej) check("swap_below", 64'(stk[stk_size - 2]), 64'(av));
    check("scoreboard_empty", 64'(push_q.size() + pop_q.size() + done_q.size()), 64'(0));
  endtask

  initial begin
    int t;
    ld_en = 1'b1;
    ld_size = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_push", 64'(stack_push), 64'(0));
    check("rst_pop", 64'(stack_pop), 64'(0));
    check("rst_stack_in", 64'(stack_in), 64'(0));
    reset = 1'b0;
    ld_en = 1'b0;
    tick();

    run_op(OP_ADD, 1, 2, 32'd7, 32'd5, 1);
    run_op(OP_SUB, 1, 2, 32'd3, 32'd5, 0);
    run_op(OP_MUL, 1, 2, 32'h10000, 32'h10000, 0);
    run_op(OP_MUL, 1, 3, 32'd123456, 32'd789, 0);
    run_op(OP_DIV, 1, 2, 32'd100, 32'd7, 0);
    run_op(OP_MOD, 1, 2, 32'd100, 32'd7, 1);
    run_op(OP_DIV, 1, 2, 32'hFFFFFFFF, 32'd3, 0);
    run_op(OP_DIV, 1, 2, 32'd5, 32'd9, 0);
    run_op(OP_MOD, 1, 2, $urandom, 32'($urandom_range(1, 1000)), 0);
    run_op(OP_DIV, 1, 2, $urandom, $urandom | 32'h1, 0);

    run_op(OP_DIV, 1, 2, 32'd9, 32'd0, 0);
    run_op(OP_MOD, 1, 2, 32'd9, 32'd0, 0);
    run_op(OP_ADD, 1, 1, 32'd0, 32'd4, 0);
    run_op(OP_SWAP, 1, 1, 32'd0, 32'd4, 0);
    run_op(OP_POP, 1, 0, 32'd0, 32'd0, 0);
    run_op(OP_DUP, 1, 0, 32'd0, 32'd0, 0);

    run_op(OP_SWAP, 1, 2, 32'd1, 32'd2, 1);
    run_op(OP_DUP, 0, 0, 32'd0, 32'd0, 1);
    run_op(OP_POP, 0, 0, 32'd0, 32'd0, 0);
    run_op(OP_POP, 1, 1, 32'd0, 32'd42, 0);
    run_op(OP_DUP, 1, DEPTH, 32'd5, 32'd6, 0);
    run_op(OP_DUP, 1, DEPTH - 1, 32'd5, 32'd6, 0);

    // Reset during an add: only the two pops may appear, nothing afterwards
    ld_en = 1'b1;
    ld_size = SIZE_W'(2);
    ld_a = 32'd5;
    ld_b = 32'd7;
    tick();
    ld_en = 1'b0;
    t = cyc;
    pop_q.push_back(t + 1);
    pop_q.push_back(t + 3);
    start = 1'b1;
    op = OP_ADD;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < t + 5; i++) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_err", 64'(err), 64'(0));
    check("midrst_push", 64'(stack_push), 64'(0));
    check("midrst_pop", 64'(stack_pop), 64'(0));
    check("midrst_stack_in", 64'(stack_in), 64'(0));
    reset = 1'b0;
    repeat (6) tick();
    check("midrst_size", 64'(stk_size), 64'(0));
    check("midrst_sb_empty", 64'(push_q.size() + pop_q.size() + done_q.size()), 64'(0));

    run_op(OP_ADD, 1, 2, 32'd1, 32'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
